dec_adpcm: RTL and testbench

//  4-bit ADPCM decoder core, the receive-side counterpart of the mcac encoder.
//  - Accepts one 4-bit code per handshake and reconstructs a 16-bit signed PCM sample.
//  - Uses an adaptive step-size, IMA-style algorithm: 89-entry step table, index adaptation.
//  - Sits between the serial code deframer (upstream) and the PCM output interface (downstream).

---
 rtl/mcac_pkg.sv | 31 +++
 rtl/dec_step_rom.sv | 14 +
 rtl/dec_adpcm.sv | 146 ++++++++++++++
 tb/tb_dec_adpcm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcac_pkg.sv
// Tables and types shared by the ADPCM encoder (mcac) and decoder (dec_adpcm).
package mcac_pkg;

  localparam int unsigned STEP_IDX_MAX = 88;

  localparam logic [14:0] STEP_TAB [0:88] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  // Index adjustment by code magnitude; 5-bit signed so +8 fits.
  localparam logic signed [4:0] IDX_ADJ [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  localparam logic signed [15:0] PCM_MIN = 16'sh8000;
  localparam logic signed [15:0] PCM_MAX = 16'sh7FFF;

  typedef enum logic [1:0] {IDLE, CALC, UPD, HOLD} dec_state_e;

endpackage

// File: rtl/dec_step_rom.sv
// Combinational step-size lookup; out-of-range indices return the largest step.
module dec_step_rom
  import mcac_pkg::*;
(
  input  logic [6:0]  idx,
  output logic [14:0] step
);

  always_comb begin
    step = 15'h7FFF;
    if (idx <= 7'(STEP_IDX_MAX)) step = STEP_TAB[idx];
  end

endmodule

// File: rtl/dec_adpcm.sv
// IMA-style 4-bit ADPCM decoder: one code per handshake -> one saturated PCM sample.
// Optional clip counter on o_clip_cnt when DEC_ADPCM_CLIP_CNT_EN is defined.
module dec_adpcm
  import mcac_pkg::*;
#(
  parameter int unsigned IDX_MAX = STEP_IDX_MAX,
  parameter int unsigned PCM_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [3:0]       i_code,
  input  logic             i_sync,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [PCM_W-1:0] o_pcm,
`ifdef DEC_ADPCM_CLIP_CNT_EN
  output logic [15:0]      o_clip_cnt,
`endif
  input  logic             scan_in0,
  input  logic             scan_en,
  output logic             scan_out0
);

  // Two guard bits: pred +/- a 17-bit diff never overflows before clamping.
  localparam int unsigned SW = PCM_W + 2;
  localparam logic signed [SW-1:0] PMax = {3'b000, {(PCM_W-1){1'b1}}};
  localparam logic signed [SW-1:0] PMin = {3'b111, {(PCM_W-1){1'b0}}};
  localparam logic signed [8:0]    IdxMaxS = 9'(IDX_MAX);

  dec_state_e state_q, state_d;

  logic [3:0]              code_q;
  logic                    sync_q;
  logic [16:0]             diff_q, diff_d;
  logic signed [PCM_W-1:0] pred_q;
  logic [6:0]              idx_q, idx_next, rom_idx;
  logic [PCM_W-1:0]        pcm_q;
  logic                    valid_q;
  logic [14:0]             step;

  logic signed [SW-1:0]    pred_base, diff_ext, p_sum;
  logic [PCM_W-1:0]        p_sat;
  logic signed [8:0]       idx_sum;

  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_en};
  assign scan_out0   = 1'b0;

  assign rom_idx = sync_q ? 7'd0 : idx_q;

  dec_step_rom u_step_rom (
    .idx  (rom_idx),
    .step (step)
  );

  assign diff_d = 17'(step >> 3)
                + (code_q[2] ? 17'(step)      : 17'd0)
                + (code_q[1] ? 17'(step >> 1) : 17'd0)
                + (code_q[0] ? 17'(step >> 2) : 17'd0);

  assign pred_base = sync_q ? '0 : SW'(pred_q);
  assign diff_ext  = SW'($signed({1'b0, diff_q}));
  assign p_sum     = code_q[3] ? (pred_base - diff_ext) : (pred_base + diff_ext);

  always_comb begin
    p_sat = p_sum[PCM_W-1:0];
    if (p_sum > PMax)      p_sat = PMax[PCM_W-1:0];
    else if (p_sum < PMin) p_sat = PMin[PCM_W-1:0];
  end

  assign idx_sum = $signed({2'b00, rom_idx}) + 9'(IDX_ADJ[code_q[2:0]]);

  always_comb begin
    idx_next = idx_sum[6:0];
    if (idx_sum < 9'sd0)        idx_next = 7'd0;
    else if (idx_sum > IdxMaxS) idx_next = 7'(IDX_MAX);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid) state_d = CALC;
      CALC:    state_d = UPD;
      UPD:     state_d = HOLD;
      HOLD:    if (o_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q  <= '0;
      sync_q  <= 1'b0;
      diff_q  <= '0;
      pred_q  <= '0;
      idx_q   <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (i_valid) begin
          code_q <= i_code;
          sync_q <= i_sync;
        end
        CALC: diff_q <= diff_d;
        UPD: begin
          pred_q  <= $signed(p_sat);
          pcm_q   <= p_sat;
          idx_q   <= idx_next;
          valid_q <= 1'b1;
        end
        HOLD: if (o_ready) valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = valid_q;
  assign o_pcm   = pcm_q;

`ifdef DEC_ADPCM_CLIP_CNT_EN
  logic [15:0] clip_cnt_q;
  logic        clip;

  assign clip = (p_sum > PMax) || (p_sum < PMin);

  always_ff @(posedge clk) begin
    if (reset) begin
      clip_cnt_q <= '0;
    end else if (state_q == UPD && clip && clip_cnt_q != 16'hFFFF) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  assign o_clip_cnt = clip_cnt_q;
`endif

endmodule

// File: tb/tb_dec_adpcm.sv
// Directed bench for dec_adpcm with a reference model feeding an expected-sample queue.
module tb_dec_adpcm;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_ready, i_sync;
  logic [3:0]  i_code;
  logic        o_valid, o_ready;
  logic [15:0] o_pcm;
  logic        scan_in0, scan_en, scan_out0;
`ifdef DEC_ADPCM_CLIP_CNT_EN
  logic [15:0] o_clip_cnt;
`endif

  dec_adpcm dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_code    (i_code),
    .i_sync    (i_sync),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_pcm     (o_pcm),
`ifdef DEC_ADPCM_CLIP_CNT_EN
    .o_clip_cnt(o_clip_cnt),
`endif
    .scan_in0  (scan_in0),
    .scan_en   (scan_en),
    .scan_out0 (scan_out0)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];
  int m_pred = 0;
  int m_idx  = 0;
  int m_clip = 0;
  int last_exp = 0;

  int tab [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
  };
  int adj [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] c, input logic s, output int pcm);
    int step, diff, p, ni;
    step = s ? tab[0] : tab[m_idx];
    diff = (step >> 3) + (c[2] ? step : 0) + (c[1] ? step >> 1 : 0) + (c[0] ? step >> 2 : 0);
    p = s ? 0 : m_pred;
    p = c[3] ? p - diff : p + diff;
    if (p > 32767 || p < -32768) begin
      if (m_clip < 65535) m_clip++;
    end
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    ni = (s ? 0 : m_idx) + adj[c[2:0]];
    if (ni < 0) ni = 0;
    if (ni > 88) ni = 88;
    m_pred = p;
    m_idx  = ni;
    pcm    = p;
  endtask

  task automatic model_reset();
    m_pred = 0;
    m_idx  = 0;
    m_clip = 0;
    exp_q.delete();
  endtask

  // Drive one code, wait for its sample and compare; returns with the DUT in HOLD.
  task automatic do_code(input logic [3:0] c, input logic s);
    int e, n;
    model_step(c, s, e);
    exp_q.push_back(e);
    i_code  = c;
    i_sync  = s;
    i_valid = 1'b1;
    n = 0;
    while (!i_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", int'(i_ready), 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_sync  = 1'b0;
    n = 0;
    while (!o_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 2);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pcm", int'($signed(o_pcm)), e);
      last_exp = e;
    end
    chk("index", int'(dut.idx_q), m_idx);
  endtask

  task automatic release_hold();
    @(posedge clk); #1;
    chk("valid_drop", int'(o_valid), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_clip;
    reset    = 1'b1;
    i_valid  = 1'b0;
    i_code   = 4'h0;
    i_sync   = 1'b0;
    o_ready  = 1'b1;
    scan_in0 = 1'b0;
    scan_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_i_ready", int'(i_ready), 1);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_pcm", int'(o_pcm), 0);
    chk("scan_out0", int'(scan_out0), 0);

    // Basic decode pair
    do_code(4'h4, 1'b0);
    chk("t1_pcm", int'($signed(o_pcm)), 7);
    chk("t1_idx", int'(dut.idx_q), 2);
    release_hold();
    do_code(4'hC, 1'b0);
    chk("t2_pcm", int'($signed(o_pcm)), -3);
    chk("t2_idx", int'(dut.idx_q), 4);
    release_hold();

    // Positive saturation
    prev_clip = 0;
    for (int i = 0; i < 100; i++) begin
      do_code(4'h7, 1'b0);
      release_hold();
`ifdef DEC_ADPCM_CLIP_CNT_EN
      chk("clip_mono", int'(o_clip_cnt >= 16'(prev_clip)), 1);
      chk("clip_cnt", int'(o_clip_cnt), m_clip);
      prev_clip = int'(o_clip_cnt);
`endif
    end
    chk("t3_sat", int'($signed(o_pcm)), 32767);
    chk("t3_idx", int'(dut.idx_q), 88);
`ifdef DEC_ADPCM_CLIP_CNT_EN
    chk("clip_nz", int'(o_clip_cnt != 16'd0), 1);
`endif

    // Negative saturation
    for (int i = 0; i < 10; i++) begin
      do_code(4'hF, 1'b0);
      release_hold();
    end
    chk("t3_negsat", int'($signed(o_pcm)), -32768);

    // Zero codes at index 0
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      do_code(4'h0, 1'b0);
      chk("t4_zero", int'($signed(o_pcm)), 0);
      chk("t4_idx", int'(dut.idx_q), 0);
      release_hold();
    end
    do_code(4'h8, 1'b0);
    chk("t4_neg0", int'($signed(o_pcm)), 0);
    release_hold();

    // Backpressure: pending code must not be consumed while in HOLD
    do_code(4'h6, 1'b0);
    do_code_hold_check();

    // Sync mid-stream restarts predictor and index
    do_code(4'h5, 1'b0);
    release_hold();
    do_code(4'h4, 1'b1);
    chk("t6_sync_pcm", int'($signed(o_pcm)), 7);
    chk("t6_sync_idx", int'(dut.idx_q), 2);
    release_hold();

    // Reset while in UPD drops the sample
    i_code  = 4'h7;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_in_upd", int'(dut.state_q == 2'd2), 1);
    pulse_reset();
    chk("t6_rst_ready", int'(i_ready), 1);
    chk("t6_rst_valid", int'(o_valid), 0);
    chk("t6_rst_pcm", int'(o_pcm), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_late_valid", int'(o_valid), 0);
    do_code(4'h4, 1'b0);
    chk("t6_after_rst", int'($signed(o_pcm)), 7);
    release_hold();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  task automatic do_code_hold_check();
    // Entered from do_code with o_ready high; re-drive with o_ready low
    release_hold();
    o_ready = 1'b0;
    do_code(4'h2, 1'b0);
    i_code  = 4'h3;
    i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", int'(o_valid), 1);
      chk("bp_pcm", int'($signed(o_pcm)), last_exp);
      chk("bp_ready", int'(i_ready), 0);
      chk("bp_idx", int'(dut.idx_q), m_idx);
    end
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", int'(i_ready), 1);
    do_code(4'h3, 1'b0);
    release_hold();
  endtask

endmodule
